// File: rtl/uart_rx_stream.sv
// uart_rx_stream: 8N1 UART receiver feeding a small byte FIFO that is
// presented as a valid/ready stream. Sample points sit at bit centres,
// the frame is released mid-stop-bit so back-to-back frames are caught,
// and a framing error or a reset disarms the receiver until the line idles.
module uart_rx_stream #(
    parameter int CLK_FREQ   = 48000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [PW-1:0] DEPTH_L  = PW'(FIFO_DEPTH);
    localparam logic [PW-1:0] PTR_ZERO = PW'(0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // Synchroniser, receiver and FIFO state
    logic            rx_meta_q, rx_s_q;
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            armed_q, armed_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   level_q, level_d, cur_level_s;
    logic [7:0]      out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;
    logic            push_req_s, push_ok_s, pop_s;

    // Receiver FSM: start qualification, centre sampling, stop-bit check
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        armed_d     = armed_q;
        push_req_s  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_s_q) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = S_START;
                    cnt_d   = CNT_HALF;
                end else begin
                    armed_d = armed_q;
                end
            end
            S_START: begin
                if (cnt_q == CNT_ZERO) begin
                    if (!rx_s_q) begin
                        state_d   = S_DATA;
                        cnt_d     = CNT_FULL;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_ZERO) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    cnt_d   = CNT_FULL;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_ZERO) begin
                    state_d = S_IDLE;
                    armed_d = rx_s_q;
                    if (rx_s_q) begin
                        push_req_s = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping; a full FIFO still accepts a byte when it pops the same cycle
    always_comb begin
        mem_d       = mem_q;
        pop_s       = out_valid_q && out_ready;
        cur_level_s = wr_ptr_q - rd_ptr_q;
        push_ok_s   = push_req_s && ((cur_level_s != DEPTH_L) || pop_s);
        overrun_d   = push_req_s && !push_ok_s;
        if (push_ok_s) begin
            mem_d[wr_ptr_q[AW-1:0]] = shift_q;
        end else begin
            mem_d[wr_ptr_q[AW-1:0]] = mem_q[wr_ptr_q[AW-1:0]];
        end
        wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, push_ok_s};
        rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, pop_s};
        level_d     = wr_ptr_d - rd_ptr_d;
        out_valid_d = (level_d != PTR_ZERO);
        if (out_valid_d) begin
            out_data_d = mem_d[rd_ptr_d[AW-1:0]];
        end else begin
            out_data_d = out_data_q;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= CNT_ZERO;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            armed_q     <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q    <= PTR_ZERO;
            rd_ptr_q    <= PTR_ZERO;
            level_q     <= PTR_ZERO;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            armed_q     <= armed_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign level     = level_q;

endmodule

// File: tb/tb_uart_rx_stream.sv
// Directed bench for uart_rx_stream at 416 clocks per bit, 4-entry FIFO.
module tb_uart_rx_stream;

    localparam int BIT = 416;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       frame_err;
    logic       overrun;
    logic [2:0] level;

    int checks;
    int errors;
    int fe_cnt;
    int ov_cnt;
    logic [7:0] popped[$];

    uart_rx_stream #(
        .CLK_FREQ  (48000000),
        .BAUD      (115200),
        .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .level    (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count pulses and record every accepted byte, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (frame_err && overrun) begin
                errors++;
                $display("FAIL pulse_exclusive: frame_err=%0b overrun=%0b, required not both", frame_err, overrun);
            end
            if (out_valid && out_ready) popped.push_back(out_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // mode 0: plain frame; 1: check out_valid rises right after stop sample;
    // 2: pulse out_ready for the single cycle that ends at the stop sample edge
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int mode);
        rx = 1'b0;
        repeat (BIT) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) tick();
        end
        rx = stop_bit;
        if (mode == 1) begin
            repeat (210) tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL latency_early: out_valid=%0b required 0", out_valid);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL latency_valid: out_valid=%0b required 1", out_valid);
            end
            checks++;
            if (out_data !== b) begin
                errors++;
                $display("FAIL latency_data: out_data=%02h required %02h", out_data, b);
            end
            repeat (BIT - 211) tick();
        end else if (mode == 2) begin
            repeat (210) tick();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            repeat (BIT - 211) tick();
        end else begin
            repeat (BIT) tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx = 1'b1;
        out_ready = 1'b0;
        repeat (5) tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b required 0", out_valid); end
        checks++;
        if (out_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %02h required 00", out_data); end
        checks++;
        if (level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d required 0", level); end
        checks++;
        if (frame_err !== 1'b0 || overrun !== 1'b0) begin
            errors++; $display("FAIL rst_pulses: frame_err=%0b overrun=%0b required 0 0", frame_err, overrun);
        end
        rst_n = 1'b1;
        repeat (2000) tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %0b required 0", out_valid); end
        checks++;
        if (level !== 3'd0) begin errors++; $display("FAIL idle_level: got %0d required 0", level); end
        checks++;
        if (fe_cnt !== 0 || ov_cnt !== 0) begin
            errors++; $display("FAIL idle_pulses: fe=%0d ov=%0d required 0 0", fe_cnt, ov_cnt);
        end
    endtask

    task automatic test_single();
        popped.delete();
        out_ready = 1'b1;
        send_byte(8'hA5, 1'b1, 1);
        checks++;
        if (popped.size() !== 1) begin
            errors++; $display("FAIL single_count: got %0d bytes required 1", popped.size());
        end else begin
            checks++;
            if (popped[0] !== 8'hA5) begin errors++; $display("FAIL single_data: got %02h required a5", popped[0]); end
        end
        checks++;
        if (level !== 3'd0) begin errors++; $display("FAIL single_level: got %0d required 0", level); end
    endtask

    task automatic test_burst();
        popped.delete();
        out_ready = 1'b0;
        ov_cnt = 0;
        fe_cnt = 0;
        for (int i = 0; i < 8; i++) send_byte(8'(i), 1'b1, 0);
        checks++;
        if (level !== 3'd4) begin errors++; $display("FAIL burst_level: got %0d required 4", level); end
        checks++;
        if (out_data !== 8'h00 || out_valid !== 1'b1) begin
            errors++; $display("FAIL burst_head: data=%02h valid=%0b required 00 1", out_data, out_valid);
        end
        checks++;
        if (ov_cnt !== 4) begin errors++; $display("FAIL burst_overrun: got %0d required 4", ov_cnt); end
        checks++;
        if (fe_cnt !== 0) begin errors++; $display("FAIL burst_ferr: got %0d required 0", fe_cnt); end
        out_ready = 1'b1;
        repeat (8) tick();
        out_ready = 1'b0;
        checks++;
        if (popped.size() !== 4) begin
            errors++; $display("FAIL burst_drain_count: got %0d required 4", popped.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (popped[i] !== 8'(i)) begin
                    errors++; $display("FAIL burst_drain_%0d: got %02h required %02h", i, popped[i], 8'(i));
                end
            end
        end
        checks++;
        if (level !== 3'd0) begin errors++; $display("FAIL burst_empty: got %0d required 0", level); end
    endtask

    task automatic test_frame_err();
        popped.delete();
        out_ready = 1'b0;
        fe_cnt = 0;
        ov_cnt = 0;
        send_byte(8'h3C, 1'b0, 0);
        rx = 1'b1;
        repeat (100) tick();
        checks++;
        if (fe_cnt !== 1) begin errors++; $display("FAIL ferr_count: got %0d required 1", fe_cnt); end
        checks++;
        if (level !== 3'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL ferr_level: level=%0d valid=%0b required 0 0", level, out_valid);
        end
        // held-low break: exactly one more frame error
        rx = 1'b0;
        repeat (BIT * 11) tick();
        rx = 1'b1;
        repeat (500) tick();
        checks++;
        if (fe_cnt !== 2) begin errors++; $display("FAIL break_count: got %0d required 2", fe_cnt); end
        out_ready = 1'b1;
        send_byte(8'h5A, 1'b1, 0);
        checks++;
        if (popped.size() !== 1 || popped[0] !== 8'h5A) begin
            errors++; $display("FAIL ferr_recover: got %0d bytes first %02h required 1 5a", popped.size(), popped[0]);
        end
        checks++;
        if (ov_cnt !== 0 || fe_cnt !== 2) begin
            errors++; $display("FAIL ferr_recover_pulses: ov=%0d fe=%0d required 0 2", ov_cnt, fe_cnt);
        end
    endtask

    task automatic test_glitch();
        popped.delete();
        fe_cnt = 0;
        out_ready = 1'b1;
        rx = 1'b0;
        repeat (100) tick();
        rx = 1'b1;
        repeat (1000) tick();
        checks++;
        if (fe_cnt !== 0 || popped.size() !== 0 || level !== 3'd0) begin
            errors++; $display("FAIL glitch: fe=%0d bytes=%0d level=%0d required 0 0 0", fe_cnt, popped.size(), level);
        end
        send_byte(8'h11, 1'b1, 0);
        checks++;
        if (popped.size() !== 1 || popped[0] !== 8'h11) begin
            errors++; $display("FAIL glitch_after: got %0d bytes first %02h required 1 11", popped.size(), popped[0]);
        end
    endtask

    task automatic test_reset_mid();
        popped.delete();
        fe_cnt = 0;
        ov_cnt = 0;
        out_ready = 1'b1;
        rx = 1'b0;
        repeat (BIT) tick();
        rx = 1'b1;
        repeat (BIT * 3 + 200) tick();
        rst_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || level !== 3'd0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: valid=%0b data=%02h level=%0d fe=%0b ov=%0b required 0 00 0 0 0",
                     out_valid, out_data, level, frame_err, overrun);
        end
        rst_n = 1'b1;
        repeat (BIT - 203 + BIT * 5) tick();
        checks++;
        if (popped.size() !== 0 || out_valid !== 1'b0 || fe_cnt !== 0 || ov_cnt !== 0) begin
            errors++;
            $display("FAIL midrst_partial: bytes=%0d valid=%0b fe=%0d ov=%0d required 0 0 0 0",
                     popped.size(), out_valid, fe_cnt, ov_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [5];
        exp[0] = 8'h10; exp[1] = 8'h11; exp[2] = 8'h12; exp[3] = 8'h13; exp[4] = 8'h77;
        popped.delete();
        ov_cnt = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(exp[i], 1'b1, 0);
        checks++;
        if (level !== 3'd4) begin errors++; $display("FAIL b2b_full: got %0d required 4", level); end
        send_byte(8'h77, 1'b1, 2);
        checks++;
        if (ov_cnt !== 0) begin errors++; $display("FAIL b2b_overrun: got %0d required 0", ov_cnt); end
        checks++;
        if (level !== 3'd4) begin errors++; $display("FAIL b2b_level: got %0d required 4", level); end
        out_ready = 1'b1;
        repeat (8) tick();
        out_ready = 1'b0;
        checks++;
        if (popped.size() !== 5) begin
            errors++; $display("FAIL b2b_count: got %0d required 5", popped.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (popped[i] !== exp[i]) begin
                    errors++; $display("FAIL b2b_data_%0d: got %02h required %02h", i, popped[i], exp[i]);
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        fe_cnt = 0;
        ov_cnt = 0;
        rst_n = 1'b0;
        rx = 1'b1;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
